// File: rtl/nx_fifo_prefetch_ctrl_if.sv
// Handshake bundle between the prefetch controller and its FIFOs/consumer.
interface nx_fifo_prefetch_ctrl_if #(
    parameter int unsigned NCH   = 6,
    parameter int unsigned CNT_W = 16
);
    logic [NCH-1:0]       ch_en;
    logic [NCH-1:0]       ef_b;
    logic [NCH-1:0]       pop;
    logic [NCH-1:0]       rden_b;
    logic [NCH-1:0]       reg_en;
    logic [NCH-1:0]       pok;
    logic [NCH-1:0]       underflow;
    logic [NCH*CNT_W-1:0] pop_cnt;

    // Controller side: drives FIFO strobes and status.
    modport master (
        input  ch_en, ef_b, pop,
        output rden_b, reg_en, pok, underflow, pop_cnt
    );

    // Environment side: FIFOs, enables and consumer.
    modport slave (
        output ch_en, ef_b, pop,
        input  rden_b, reg_en, pok, underflow, pop_cnt
    );
endinterface

// File: rtl/nx_fifo_prefetch_ctrl.sv
// N-channel FIFO prefetch read controller: keeps one word primed per channel.
module nx_fifo_prefetch_ctrl #(
    parameter int unsigned NCH    = 6,
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       init,
    nx_fifo_prefetch_ctrl_if.master    bus
);
    localparam int unsigned LW = $clog2(RD_LAT + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_VALID} state_e;

    state_e               state_q [NCH];
    state_e               state_d [NCH];
    logic [LW-1:0]        lat_q   [NCH];
    logic [LW-1:0]        lat_d   [NCH];
    logic [NCH-1:0]       rden_b_q, rden_b_d;
    logic [NCH-1:0]       reg_en_q, reg_en_d;
    logic [NCH-1:0]       pok_q, pok_d;
    logic [NCH-1:0]       underflow_q, underflow_d;
    logic [NCH*CNT_W-1:0] cnt_q, cnt_d;
    logic [NCH-1:0]       issue_c;
    logic [NCH-1:0]       popped_c;

    // Per-channel read decision, FSM advance, strobes and bookkeeping.
    always_comb begin
        state_d     = state_q;
        lat_d       = lat_q;
        rden_b_d    = '1;
        reg_en_d    = '0;
        pok_d       = '0;
        underflow_d = underflow_q;
        cnt_d       = cnt_q;
        issue_c     = '0;
        popped_c    = '0;
        for (int i = 0; i < NCH; i++) begin
            popped_c[i] = bus.pop[i] && (state_q[i] == S_VALID);
            issue_c[i]  = bus.ch_en[i] && bus.ef_b[i] &&
                          ((state_q[i] == S_IDLE) || popped_c[i]);
            // A pop with nothing held is ignored but remembered.
            if (bus.pop[i] && (state_q[i] != S_VALID)) begin
                underflow_d[i] = 1'b1;
            end
            case (state_q[i])
                S_IDLE: begin
                    if (issue_c[i]) begin
                        state_d[i] = S_WAIT;
                        lat_d[i]   = LW'(RD_LAT);
                    end
                end
                S_WAIT: begin
                    reg_en_d[i] = (lat_q[i] == LW'(1));
                    if (lat_q[i] == LW'(0)) begin
                        state_d[i] = S_VALID;
                    end else begin
                        lat_d[i] = lat_q[i] - LW'(1);
                    end
                end
                S_VALID: begin
                    if (popped_c[i]) begin
                        cnt_d[i*CNT_W +: CNT_W] = cnt_q[i*CNT_W +: CNT_W] + CNT_W'(1);
                        if (issue_c[i]) begin
                            state_d[i] = S_WAIT;
                            lat_d[i]   = LW'(RD_LAT);
                        end else begin
                            state_d[i] = S_IDLE;
                        end
                    end
                end
                default: state_d[i] = S_IDLE;
            endcase
            rden_b_d[i] = ~issue_c[i];
            pok_d[i]    = (state_d[i] == S_VALID);
        end
    end

    // State and output registers; init wins over everything.
    always_ff @(posedge clk) begin
        if (init) begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= S_IDLE;
                lat_q[i]   <= '0;
            end
            rden_b_q    <= '1;
            reg_en_q    <= '0;
            pok_q       <= '0;
            underflow_q <= '0;
            cnt_q       <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= state_d[i];
                lat_q[i]   <= lat_d[i];
            end
            rden_b_q    <= rden_b_d;
            reg_en_q    <= reg_en_d;
            pok_q       <= pok_d;
            underflow_q <= underflow_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.rden_b    = rden_b_q;
    assign bus.reg_en    = reg_en_q;
    assign bus.pok       = pok_q;
    assign bus.underflow = underflow_q;
    assign bus.pop_cnt   = cnt_q;

endmodule
